// File: rtl/uart_pkg.sv
// Shared definitions for the result UART transmitter: state encoding,
// frame geometry and the baud divisor helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS = 8;
    localparam int NUM_BYTES = 2;

    // Clock cycles per bit; integer truncation of the ratio.
    function automatic int UART_DIV(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1, wraps, and flags the last cycle of
// each bit period. The FSM restarts it when a new frame pair begins so the
// first start bit is exactly DIV cycles long.
module uart_baud_gen #(
    parameter int DIV = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: restart wins, otherwise wrap at the last cycle of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = {W{1'b0}};
        end else if (cnt_q == LAST) begin
            cnt_d = {W{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_result_tx.sv
// Sends a 16-bit result word as two 8N1 bytes, high byte first, using a
// valid/ready capture so the line is never disturbed by upstream changes.
module uart_result_tx
    import uart_pkg::*;
#(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 57600,
    parameter int p_N            = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [p_N-1:0] i_data,
    input  logic           i_valid,
    output logic           o_ready,
    output logic           uart_txd,
    output logic           o_busy,
    output logic           o_done
);

    localparam int DIV = UART_DIV(clk_freq, uart_baud_rate);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_BYTE = 1'(NUM_BYTES - 1);

    uart_state_e    state_d, state_q;
    logic [p_N-1:0] buf_d, buf_q;
    logic [2:0]     bit_d, bit_q;
    logic           byte_d, byte_q;
    logic           txd_d, txd_q;
    logic           done_d, done_q;
    logic           restart_s;
    logic           tick_s;
    logic [2:0]     nxt_bit_s;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (restart_s),
        .tick    (tick_s)
    );

    assign nxt_bit_s = bit_q + 3'd1;

    // Next-state logic; txd_d is the line level for the next cycle so the
    // pin is driven straight from a flop. Byte 0 lives in buf[15:8], so the
    // bit index is {~byte, bit}.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        txd_d     = txd_q;
        done_d    = 1'b0;
        restart_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_d   = ST_START;
                    buf_d     = i_data;
                    byte_d    = 1'b0;
                    bit_d     = 3'd0;
                    txd_d     = 1'b0;
                    restart_s = 1'b1;
                end else begin
                    txd_d = 1'b1;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    txd_d   = buf_q[{~byte_q, 3'd0}];
                end else begin
                    txd_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = nxt_bit_s;
                        txd_d = buf_q[{~byte_q, nxt_bit_s}];
                    end
                end else begin
                    txd_d = buf_q[{~byte_q, bit_q}];
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_START;
                        byte_d  = LAST_BYTE;
                        txd_d   = 1'b0;
                    end
                end else begin
                    txd_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // FSM and datapath registers; reset drives the line high immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            buf_q   <= {p_N{1'b0}};
            bit_q   <= 3'd0;
            byte_q  <= 1'b0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_busy   = (state_q != ST_IDLE);
    assign uart_txd = txd_q;
    assign o_done   = done_q;

endmodule
